mux_4_1_rr_arbiter: RTL

//  Round-robin arbiter that shares one 4:1 multiplexer between four requesters.

---
 rtl/mux_4_1_rr_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux.
// The owner keeps the grant while it requests, up to MAX_HOLD consecutive
// cycles; then arbitration restarts one past the owner so it becomes the
// lowest-priority candidate.
module mux_4_1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       gnt_valid
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  state_e        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic       w_found;
  logic [1:0] w_idx;
  logic       w_hold_out;
  logic       w_do_grant;
  logic       w_do_drop;
  logic       w_do_count;

  // First asserted request at or after r_ptr; descending loop so the smallest offset wins.
  // r_ptr always sits one past the current owner, so release and timeout share this search.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_idx   = r_ptr + 2'(i);
      end
    end
  end

  assign w_hold_out = (r_cnt == CW'(MAX_HOLD));

  // Decide this edge's action: new grant, release to idle, or keep counting.
  always_comb begin
    w_do_grant = 1'b0;
    w_do_drop  = 1'b0;
    w_do_count = 1'b0;
    case (r_state)
      StIdle: begin
        w_do_grant = en && w_found;
      end
      StGrant: begin
        if (!en) begin
          w_do_drop = 1'b1;
        end else if (!req[sel]) begin
          // Release wins over a coincident timeout.
          w_do_grant = w_found;
          w_do_drop  = !w_found;
        end else if (w_hold_out) begin
          // Owner is still requesting, so the search always finds someone (maybe the owner).
          w_do_grant = 1'b1;
        end else begin
          w_do_count = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      gnt_valid <= 1'b0;
    end else if (w_do_grant) begin
      r_state   <= StGrant;
      r_ptr     <= w_idx + 2'd1;
      r_cnt     <= CW'(1);
      gnt       <= 4'b0001 << w_idx;
      sel       <= w_idx;
      gnt_valid <= 1'b1;
    end else if (w_do_drop) begin
      // sel deliberately keeps its last value.
      r_state   <= StIdle;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
    end else if (w_do_count) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
